pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush/freeze sequencer for the 5-stage RV32 pipeline. It merges the load-use stall request from hazard detection, the taken-branch redirect resolved in EX, the data-memory wait handshake in MEM, and the halt request retired in WB. From these it drives one consistent set of per-stage write enables and flushes. A small FSM adds a memory-wait watchdog and a terminal halt state.

## Interface
Parameters:
- MEM_TIMEOUT, 255: number of consecutive not-ready memory cycles before a bus error is declared (≥1).
- CNT_W, 32: width of performance counters (only with PIPE_CTRL_PERF_EN).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset; synchronous, active-low.
- hdu_stall  in  1  load-use stall request from hazard detection (ID vs EX load).
- branch_taken  in  1  branch/jump in EX redirects the PC this cycle.
- mem_req  in  1  MEM-stage instruction is a load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- halt_req  in  1  ecall/ebreak retiring in WB.
- pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1 each  stage register enables.
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble (NOP, all control zero).
- halted  out  1  registered; pipeline permanently frozen.
- mem_err  out  1  registered, sticky; watchdog expired.
- stall_cycles, flush_count, memwait_cycles  out  CNT_W each  perf counters (PIPE_CTRL_PERF_EN only).

## Operation
- States: RUN, MEM_WAIT, HALT. Reset state RUN.
- Control outputs are Mealy, combinational from state and inputs. Defaults: all *_write=1, all flushes=0.
- RUN, evaluated in this priority order:
  1. mem_req && !mem_ready: freeze. All *_write=0 except mem_wb_write=1. mem_wb_flush=1. branch_taken and hdu_stall are ignored because EX/ID are held and will reassert. Next state MEM_WAIT.
  2. halt_req: all *_write=0. Next state HALT.
  3. branch_taken: if_id_flush=1, id_ex_flush=1, pc_write=1. hdu_stall is ignored because the dependent instruction is flushed.
  4. hdu_stall: pc_write=0, if_id_write=0, id_ex_flush=1 (bubble into EX). Other stages advance.
- MEM_WAIT:
  - mem_ready=0: freeze exactly as in RUN item 1.
  - mem_ready=1: outputs equal the RUN outputs for the same inputs, with item 1 treated as false. Next state is RUN, or HALT if halt_req.
- Watchdog: wait_cnt is cleared whenever the freeze condition is false. It increments on each freeze cycle. When wait_cnt reaches MEM_TIMEOUT, next state is HALT and mem_err is set.
- HALT: all *_write=0, all flushes=0, halted=1. Only reset exits.
- While rst_n=0: all *_write=0, flushes=0. State←RUN, wait_cnt←0, halted←0, mem_err←0, counters←0.

## Timing
- Control outputs: zero-cycle latency from inputs.
- halted rises at the first posedge after the HALT transition condition.
- mem_err rises on the same edge that enters HALT on timeout.
- With mem_ready=0 held from cycle 0, the pipeline is frozen for exactly MEM_TIMEOUT cycles, then halted=mem_err=1.
- If mem_ready rises in the same cycle wait_cnt would reach MEM_TIMEOUT, ready wins: no error.
- Reset mid-MEM_WAIT: the next cycle is RUN with wait_cnt=0.

## Configuration
- PIPE_CTRL_PERF_EN defined: three saturating CNT_W counters.
  - stall_cycles: cycles with hdu_stall acted on.
  - flush_count: branch flushes acted on.
  - memwait_cycles: freeze cycles.
  - All three hold in HALT.
- Undefined: the counter ports and their logic are absent. Control behaviour is identical.

## Structure
- pipe_ctrl_pkg: state enum (RUN/MEM_WAIT/HALT), bubble/priority constants, and a function computing wait-counter width from MEM_TIMEOUT.
- One sub-module, pipe_ctrl_perf: the counter bank, instantiated only under PIPE_CTRL_PERF_EN.

## Test plan
- Reset released, no requests → all *_write=1, flushes=0, halted=0 every cycle.
- hdu_stall=1 for one cycle → that cycle pc_write=0, if_id_write=0, id_ex_flush=1; next cycle all writes 1.
- branch_taken=1 and hdu_stall=1 together → if_id_flush=id_ex_flush=1, pc_write=1, if_id_write=1.
- mem_req=1, mem_ready=0 for 3 cycles then 1, with branch_taken=1 throughout → 3 freeze cycles with mem_wb_flush=1; on the 4th cycle, branch flush outputs assert and state is RUN.
- MEM_TIMEOUT=4, mem_ready stuck 0 → 4 freeze cycles, then halted=mem_err=1. Further inputs are ignored until rst_n=0, which clears both next edge.
- halt_req=1 in RUN → next cycle halted=1 and all writes 0. With PIPE_CTRL_PERF_EN, counters freeze at their values.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for pipeline_ctrl: FSM state encoding, the
// packed per-stage control word with its canonical patterns, and the
// watchdog counter sizing helper.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_HALT     = 2'd2
    } state_t;

    // MSB first: enables for PC, IF/ID, ID/EX, EX/MEM, MEM/WB, then flushes
    // for IF/ID, ID/EX, MEM/WB.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic mem_wb_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } ctrl_t;

    // Normal advance: every stage writes, no bubbles.
    localparam ctrl_t CTRL_PASS   = ctrl_t'(8'b1111_1000);
    // Memory freeze: only MEM/WB advances, and it takes a bubble so the
    // stalled access does not retire twice.
    localparam ctrl_t CTRL_FREEZE = ctrl_t'(8'b0000_1001);
    // Everything held, no bubbles (reset, halt request, halted).
    localparam ctrl_t CTRL_HOLD   = ctrl_t'(8'b0000_0000);

    // Wide enough to hold the value MEM_TIMEOUT itself.
    function automatic int wait_cnt_w(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and pipeline_ctrl.
// master: the controller side (takes requests, drives enables/flushes).
// slave:  the datapath side.
interface pipe_ctrl_if;

    logic hdu_stall;
    logic branch_taken;
    logic mem_req;
    logic mem_ready;
    logic halt_req;

    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic mem_wb_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
    logic halted;
    logic mem_err;

    modport master (
        input  hdu_stall, branch_taken, mem_req, mem_ready, halt_req,
        output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
        output if_id_flush, id_ex_flush, mem_wb_flush, halted, mem_err
    );

    modport slave (
        output hdu_stall, branch_taken, mem_req, mem_ready, halt_req,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
        input  if_id_flush, id_ex_flush, mem_wb_flush, halted, mem_err
    );

endinterface

// File: rtl/pipe_ctrl_perf.sv
// Saturating performance counter bank for pipeline_ctrl. Only built when
// PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_perf #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_ev,
    input  logic             flush_ev,
    input  logic             wait_ev,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] memwait_cycles
);

    // Each counter stops at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles   <= '0;
            flush_count    <= '0;
            memwait_cycles <= '0;
        end else begin
            if (stall_ev && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
            if (flush_ev && (flush_count != '1))
                flush_count <= flush_count + 1'b1;
            if (wait_ev && (memwait_cycles != '1))
                memwait_cycles <= memwait_cycles + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/freeze sequencer for the 5-stage pipeline with a memory-wait
// watchdog and terminal halt. Optional perf counters: PIPE_CTRL_PERF_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; branch flush / load-use stall applied here
// MEM_WAIT | data access outstanding; frozen until mem_ready or timeout
// HALT     | terminal; everything held until reset
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_ctrl_if.master      bus
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] memwait_cycles
`endif
);

    localparam int WCW = wait_cnt_w(MEM_TIMEOUT);
    localparam logic [WCW-1:0] TIMEOUT_CNT = WCW'(MEM_TIMEOUT);

    if (MEM_TIMEOUT < 1 || CNT_W < 1) begin : g_param_check
        $error("pipeline_ctrl: MEM_TIMEOUT and CNT_W must be at least 1");
    end

    state_t         state, state_nxt;
    ctrl_t          ctrl;
    logic           freeze;
    logic           timeout;
    logic [WCW-1:0] wait_cnt;
    logic [WCW-1:0] wait_cnt_inc;
    logic           halted;
    logic           mem_err;

    assign wait_cnt_inc = wait_cnt + 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_RUN;
        else        state <= state_nxt;
    end

    // Next state and Mealy control word; priority is freeze, halt, branch, stall.
    always_comb begin
        ctrl      = CTRL_HOLD;
        state_nxt = state;
        freeze    = 1'b0;
        timeout   = 1'b0;
        if (rst_n) begin
            case (state)
                S_RUN, S_MEM_WAIT: begin
                    ctrl = CTRL_PASS;
                    if ((state == S_MEM_WAIT || bus.mem_req) && !bus.mem_ready) begin
                        freeze    = 1'b1;
                        ctrl      = CTRL_FREEZE;
                        state_nxt = S_MEM_WAIT;
                        if (wait_cnt_inc == TIMEOUT_CNT) begin
                            timeout   = 1'b1;
                            state_nxt = S_HALT;
                        end
                    end else if (bus.halt_req) begin
                        ctrl      = CTRL_HOLD;
                        state_nxt = S_HALT;
                    end else begin
                        state_nxt = S_RUN;
                        if (bus.branch_taken) begin
                            ctrl.if_id_flush = 1'b1;
                            ctrl.id_ex_flush = 1'b1;
                        end else if (bus.hdu_stall) begin
                            ctrl.pc_write    = 1'b0;
                            ctrl.if_id_write = 1'b0;
                            ctrl.id_ex_flush = 1'b1;
                        end
                    end
                end
                default: state_nxt = S_HALT;
            endcase
        end
    end

    // Watchdog count plus registered halted / sticky mem_err.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            halted   <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            wait_cnt <= freeze ? wait_cnt_inc : '0;
            halted   <= (state_nxt == S_HALT);
            if (timeout) mem_err <= 1'b1;
        end
    end

    assign bus.pc_write     = ctrl.pc_write;
    assign bus.if_id_write  = ctrl.if_id_write;
    assign bus.id_ex_write  = ctrl.id_ex_write;
    assign bus.ex_mem_write = ctrl.ex_mem_write;
    assign bus.mem_wb_write = ctrl.mem_wb_write;
    assign bus.if_id_flush  = ctrl.if_id_flush;
    assign bus.id_ex_flush  = ctrl.id_ex_flush;
    assign bus.mem_wb_flush = ctrl.mem_wb_flush;
    assign bus.halted       = halted;
    assign bus.mem_err      = mem_err;

`ifdef PIPE_CTRL_PERF_EN
    // A branch flush is the only case with if_id_flush set; a load-use
    // stall is the only case with id_ex_flush alone.
    pipe_ctrl_perf #(.CNT_W(CNT_W)) u_perf (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_ev       (ctrl.id_ex_flush && !ctrl.if_id_flush),
        .flush_ev       (ctrl.if_id_flush),
        .wait_ev        (freeze),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count),
        .memwait_cycles (memwait_cycles)
    );
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vector table, corner
// sequences, and randomized traffic against a behavioural model.
module tb_pipeline_ctrl;

    localparam int T  = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_ctrl_if bus();

`ifdef PIPE_CTRL_PERF_EN
    logic [CW-1:0] stall_cycles, flush_count, memwait_cycles;
`endif

    pipeline_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count),
        .memwait_cycles (memwait_cycles)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    bit m_halted, m_err, m_wait;
    int m_cnt, m_stall, m_flush, m_mw;

    logic [7:0] last_ctrl;
    logic       last_halted, last_err;

    typedef struct {
        logic       hs, br, rq, rd, hr;
        logic [7:0] ctrl;
        logic       halted;
    } vec_t;
    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int x);
        return (x < (1 << CW) - 1) ? x + 1 : x;
    endfunction

    // Expected control word {pc,ifid,idex,exmem,memwb writes, ifid,idex,memwb flushes}
    function automatic logic [7:0] model_ctrl(input logic rst, hs, br, rq, rd, hr,
                                              output bit frz, output bit did_br, output bit did_st);
        frz = 0; did_br = 0; did_st = 0;
        if (!rst || m_halted) return 8'h00;
        frz = m_wait ? !rd : (rq && !rd);
        if (frz) return 8'b0000_1001;
        if (hr) return 8'h00;
        if (br) begin did_br = 1; return 8'b1111_1110; end
        if (hs) begin did_st = 1; return 8'b0011_1010; end
        return 8'b1111_1000;
    endfunction

    task automatic model_update(input logic rst, hr, input bit frz, did_br, did_st);
        if (!rst) begin
            m_halted = 0; m_err = 0; m_wait = 0; m_cnt = 0;
            m_stall = 0; m_flush = 0; m_mw = 0;
        end else if (!m_halted) begin
            if (frz) begin
                m_mw = sat(m_mw);
                m_cnt++;
                if (m_cnt == T) begin
                    m_halted = 1; m_err = 1; m_wait = 0; m_cnt = 0;
                end else begin
                    m_wait = 1;
                end
            end else begin
                m_cnt = 0; m_wait = 0;
                if (hr) m_halted = 1;
                if (did_br) m_flush = sat(m_flush);
                if (did_st) m_stall = sat(m_stall);
            end
        end
    endtask

    // One clock: drive, compare at negedge against the model, advance.
    task automatic step(input logic rst, hs, br, rq, rd, hr);
        logic [7:0] e;
        bit frz, db, ds;
        rst_n            = rst;
        bus.hdu_stall    = hs;
        bus.branch_taken = br;
        bus.mem_req      = rq;
        bus.mem_ready    = rd;
        bus.halt_req     = hr;
        @(negedge clk);
        last_ctrl   = {bus.pc_write, bus.if_id_write, bus.id_ex_write, bus.ex_mem_write,
                       bus.mem_wb_write, bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush};
        last_halted = bus.halted;
        last_err    = bus.mem_err;
        e = model_ctrl(rst, hs, br, rq, rd, hr, frz, db, ds);
        check("ctrl", 32'(last_ctrl), 32'(e));
        check("halted", 32'(last_halted), 32'(m_halted));
        check("mem_err", 32'(last_err), 32'(m_err));
`ifdef PIPE_CTRL_PERF_EN
        check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        check("flush_count", 32'(flush_count), 32'(m_flush));
        check("memwait_cycles", 32'(memwait_cycles), 32'(m_mw));
`endif
        model_update(rst, hr, frz, db, ds);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int hage;
        logic rr, hs, br, rq, rd, hr;

        //            hs br rq rd hr  ctrl          halted
        tbl[0]  = '{0, 0, 0, 0, 0, 8'b1111_1000, 1'b0};
        tbl[1]  = '{1, 0, 0, 0, 0, 8'b0011_1010, 1'b0};
        tbl[2]  = '{0, 0, 0, 0, 0, 8'b1111_1000, 1'b0};
        tbl[3]  = '{1, 1, 0, 0, 0, 8'b1111_1110, 1'b0};
        tbl[4]  = '{0, 0, 1, 1, 0, 8'b1111_1000, 1'b0};
        tbl[5]  = '{0, 1, 1, 0, 0, 8'b0000_1001, 1'b0};
        tbl[6]  = '{0, 1, 1, 0, 0, 8'b0000_1001, 1'b0};
        tbl[7]  = '{0, 1, 1, 0, 0, 8'b0000_1001, 1'b0};
        tbl[8]  = '{0, 1, 1, 1, 0, 8'b1111_1110, 1'b0};
        tbl[9]  = '{1, 0, 0, 0, 0, 8'b0011_1010, 1'b0};
        tbl[10] = '{0, 0, 1, 0, 1, 8'b0000_1001, 1'b0};
        tbl[11] = '{0, 0, 1, 1, 1, 8'b0000_0000, 1'b0};
        tbl[12] = '{0, 0, 0, 0, 0, 8'b0000_0000, 1'b1};
        tbl[13] = '{0, 1, 0, 0, 0, 8'b0000_0000, 1'b1};

        rst_n = 1'b0;
        bus.hdu_stall = 0; bus.branch_taken = 0; bus.mem_req = 0;
        bus.mem_ready = 0; bus.halt_req = 0;
        repeat (2) @(posedge clk);
        #1;
        model_update(1'b0, 1'b0, 0, 0, 0);

        // Reset held: everything frozen
        step(0, 1, 1, 1, 0, 1);
        check("rst_ctrl", 32'(last_ctrl), 32'h00);
        repeat (3) begin
            step(1, 0, 0, 0, 0, 0);
            check("idle_ctrl", 32'(last_ctrl), 32'hF8);
            check("idle_halted", 32'(last_halted), 32'h0);
        end

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            step(1, tbl[i].hs, tbl[i].br, tbl[i].rq, tbl[i].rd, tbl[i].hr);
            check($sformatf("tbl%0d_ctrl", i), 32'(last_ctrl), 32'(tbl[i].ctrl));
            check($sformatf("tbl%0d_halted", i), 32'(last_halted), 32'(tbl[i].halted));
        end
        step(0, 0, 0, 0, 0, 0);

        // Watchdog expiry: T freeze cycles, then halted and mem_err
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < T; i++) begin
            step(1, 0, 0, 1, 0, 0);
            check("to_freeze", 32'(last_ctrl), 32'h09);
            check("to_not_halted", 32'(last_halted), 32'h0);
        end
        step(1, 0, 0, 0, 0, 0);
        check("to_halted", 32'(last_halted), 32'h1);
        check("to_mem_err", 32'(last_err), 32'h1);
        check("to_ctrl", 32'(last_ctrl), 32'h00);
        repeat (3) begin
            step(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            check("halt_hold", 32'(last_ctrl), 32'h00);
        end
        step(0, 0, 0, 0, 0, 0);
        check("halt_rst_ctrl", 32'(last_ctrl), 32'h00);
        step(1, 0, 0, 0, 0, 0);
        check("post_rst_halted", 32'(last_halted), 32'h0);
        check("post_rst_mem_err", 32'(last_err), 32'h0);
        check("post_rst_ctrl", 32'(last_ctrl), 32'hF8);

        // Ready arrives on the cycle the count would expire: no error
        repeat (T - 1) step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 1, 0);
        check("ready_wins_ctrl", 32'(last_ctrl), 32'hF8);
        step(1, 0, 0, 0, 0, 0);
        check("ready_wins_halted", 32'(last_halted), 32'h0);
        check("ready_wins_err", 32'(last_err), 32'h0);

        // Reset in the middle of MEM_WAIT restarts in RUN with a clean count
        repeat (2) step(1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("midrst_run", 32'(last_ctrl), 32'hF8);
        repeat (T - 1) step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 1, 0);
        check("midrst_halted", 32'(last_halted), 32'h0);
        check("midrst_err", 32'(last_err), 32'h0);

        // Randomized traffic against the model
        hage = 0;
        for (int i = 0; i < 3000; i++) begin
            hage = m_halted ? hage + 1 : 0;
            rr = !(hage > 2) && ($urandom_range(63) != 0);
            hs = 1'($urandom_range(3) == 0);
            br = 1'($urandom_range(3) == 0);
            rq = 1'($urandom_range(2) == 0);
            rd = 1'($urandom_range(2) != 0);
            hr = 1'($urandom_range(39) == 0);
            step(rr, hs, br, rq, rd, hr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
